// File: rtl/mem_arbiter.sv
// Shares one AXI4-Lite-style slave port between the IFU and the LSU.
// Exactly one transaction is outstanding at a time; the payload is never buffered.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit RR_MODE = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   ifu_araddr_i,
    input  logic                ifu_arvalid_i,
    output logic                ifu_arready_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic [1:0]          ifu_rresp_o,
    output logic                ifu_rvalid_o,
    input  logic                ifu_rready_i,
    input  logic [ADDR_W-1:0]   lsu_araddr_i,
    input  logic                lsu_arvalid_i,
    output logic                lsu_arready_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic [1:0]          lsu_rresp_o,
    output logic                lsu_rvalid_o,
    input  logic                lsu_rready_i,
    input  logic [ADDR_W-1:0]   lsu_awaddr_i,
    input  logic                lsu_awvalid_i,
    output logic                lsu_awready_o,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    input  logic                lsu_wvalid_i,
    output logic                lsu_wready_o,
    output logic [1:0]          lsu_bresp_o,
    output logic                lsu_bvalid_o,
    input  logic                lsu_bready_i,
    output logic [ADDR_W-1:0]   s_araddr_o,
    output logic                s_arvalid_o,
    input  logic                s_arready_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic [1:0]          s_rresp_i,
    input  logic                s_rvalid_i,
    output logic                s_rready_o,
    output logic [ADDR_W-1:0]   s_awaddr_o,
    output logic                s_awvalid_o,
    input  logic                s_awready_i,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    output logic                s_wvalid_o,
    input  logic                s_wready_i,
    input  logic [1:0]          s_bresp_i,
    input  logic                s_bvalid_i,
    output logic                s_bready_o,
    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

    state_e     state_q;
    logic [1:0] grant_q;
    logic       ar_done_q;
    logic       aw_done_q;
    logic       w_done_q;
    logic       lsu_prio_q;

    logic lsu_wr_req;
    logic lsu_req;
    logic pick_lsu;
    logic wr_done;
    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic r_hs;
    logic b_hs;

    assign lsu_wr_req = lsu_awvalid_i | lsu_wvalid_i;
    assign lsu_req    = lsu_wr_req | lsu_arvalid_i;
    // Fixed priority lets the LSU win any conflict; round-robin defers to the pointer.
    assign pick_lsu   = lsu_req & (~ifu_arvalid_i | ~RR_MODE | lsu_prio_q);
    assign wr_done    = aw_done_q & w_done_q;

    assign ar_hs = s_arvalid_o & s_arready_i;
    assign aw_hs = s_awvalid_o & s_awready_i;
    assign w_hs  = s_wvalid_o & s_wready_i;
    assign r_hs  = s_rvalid_i & s_rready_o;
    assign b_hs  = s_bvalid_i & s_bready_o;

    assign s_awaddr_o  = lsu_awaddr_i;
    assign s_wdata_o   = lsu_wdata_i;
    assign s_wstrb_o   = lsu_wstrb_i;
    assign ifu_rdata_o = s_rdata_i;
    assign ifu_rresp_o = s_rresp_i;
    assign lsu_rdata_o = s_rdata_i;
    assign lsu_rresp_o = s_rresp_i;
    assign lsu_bresp_o = s_bresp_i;
    assign grant_o     = grant_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= 2'd0;
            ar_done_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            lsu_prio_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_lsu) begin
                        state_q <= lsu_wr_req ? LSU_WR : LSU_RD;
                        grant_q <= lsu_wr_req ? 2'd3 : 2'd2;
                    end else if (ifu_arvalid_i) begin
                        state_q <= IFU_RD;
                        grant_q <= 2'd1;
                    end
                end
                IFU_RD, LSU_RD: begin
                    if (ar_hs) ar_done_q <= 1'b1;
                    if (r_hs) begin
                        state_q    <= IDLE;
                        grant_q    <= 2'd0;
                        ar_done_q  <= 1'b0;
                        lsu_prio_q <= (state_q == IFU_RD);
                    end
                end
                LSU_WR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs) w_done_q <= 1'b1;
                    if (b_hs) begin
                        state_q    <= IDLE;
                        grant_q    <= 2'd0;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        lsu_prio_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_araddr_o    = (state_q == LSU_RD) ? lsu_araddr_i : ifu_araddr_i;
        s_arvalid_o   = 1'b0;
        s_rready_o    = 1'b0;
        s_awvalid_o   = 1'b0;
        s_wvalid_o    = 1'b0;
        s_bready_o    = 1'b0;
        ifu_arready_o = 1'b0;
        ifu_rvalid_o  = 1'b0;
        lsu_arready_o = 1'b0;
        lsu_rvalid_o  = 1'b0;
        lsu_awready_o = 1'b0;
        lsu_wready_o  = 1'b0;
        lsu_bvalid_o  = 1'b0;
        unique case (state_q)
            IFU_RD: begin
                s_arvalid_o   = ifu_arvalid_i & ~ar_done_q;
                ifu_arready_o = s_arready_i & ~ar_done_q;
                s_rready_o    = ifu_rready_i & ar_done_q;
                ifu_rvalid_o  = s_rvalid_i & ar_done_q;
            end
            LSU_RD: begin
                s_arvalid_o   = lsu_arvalid_i & ~ar_done_q;
                lsu_arready_o = s_arready_i & ~ar_done_q;
                s_rready_o    = lsu_rready_i & ar_done_q;
                lsu_rvalid_o  = s_rvalid_i & ar_done_q;
            end
            LSU_WR: begin
                s_awvalid_o   = lsu_awvalid_i & ~aw_done_q;
                lsu_awready_o = s_awready_i & ~aw_done_q;
                s_wvalid_o    = lsu_wvalid_i & ~w_done_q;
                lsu_wready_o  = s_wready_i & ~w_done_q;
                s_bready_o    = lsu_bready_i & wr_done;
                lsu_bvalid_o  = s_bvalid_i & wr_done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: dut_a uses fixed priority, dut_b round-robin.
// Both share stimulus; each scenario checks the instance it targets.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, s_rdata;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic        lsu_awvalid, lsu_wvalid, lsu_bready;
    logic [3:0]  lsu_wstrb;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [1:0]  s_rresp, s_bresp;

    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    logic        lsu_awready, lsu_wready, lsu_bvalid;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, grant;
    logic [3:0]  s_wstrb;

    logic        ifu_arready_b, ifu_rvalid_b, lsu_arready_b, lsu_rvalid_b;
    logic        lsu_awready_b, lsu_wready_b, lsu_bvalid_b;
    logic        s_arvalid_b, s_rready_b, s_awvalid_b, s_wvalid_b, s_bready_b;
    logic [31:0] ifu_rdata_b, lsu_rdata_b, s_araddr_b, s_awaddr_b, s_wdata_b;
    logic [1:0]  ifu_rresp_b, lsu_rresp_b, lsu_bresp_b, grant_b;
    logic [3:0]  s_wstrb_b;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready),
        .ifu_rdata_o(ifu_rdata), .ifu_rresp_o(ifu_rresp), .ifu_rvalid_o(ifu_rvalid),
        .ifu_rready_i(ifu_rready),
        .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready),
        .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp), .lsu_rvalid_o(lsu_rvalid),
        .lsu_rready_i(lsu_rready),
        .lsu_awaddr_i(lsu_awaddr), .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready),
        .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_wvalid_i(lsu_wvalid),
        .lsu_wready_o(lsu_wready),
        .lsu_bresp_o(lsu_bresp), .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready),
        .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
        .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
        .s_awaddr_o(s_awaddr), .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
        .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready),
        .grant_o(grant)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_MODE(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready_b),
        .ifu_rdata_o(ifu_rdata_b), .ifu_rresp_o(ifu_rresp_b), .ifu_rvalid_o(ifu_rvalid_b),
        .ifu_rready_i(ifu_rready),
        .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready_b),
        .lsu_rdata_o(lsu_rdata_b), .lsu_rresp_o(lsu_rresp_b), .lsu_rvalid_o(lsu_rvalid_b),
        .lsu_rready_i(lsu_rready),
        .lsu_awaddr_i(lsu_awaddr), .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready_b),
        .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_wvalid_i(lsu_wvalid),
        .lsu_wready_o(lsu_wready_b),
        .lsu_bresp_o(lsu_bresp_b), .lsu_bvalid_o(lsu_bvalid_b), .lsu_bready_i(lsu_bready),
        .s_araddr_o(s_araddr_b), .s_arvalid_o(s_arvalid_b), .s_arready_i(s_arready),
        .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready_b),
        .s_awaddr_o(s_awaddr_b), .s_awvalid_o(s_awvalid_b), .s_awready_i(s_awready),
        .s_wdata_o(s_wdata_b), .s_wstrb_o(s_wstrb_b), .s_wvalid_o(s_wvalid_b),
        .s_wready_i(s_wready),
        .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready_b),
        .grant_o(grant_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_wvalid = 0; lsu_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        s_rvalid = 1; s_bvalid = 1; s_arready = 1; s_awready = 1; s_wready = 1;
        tick(); tick();
        rst = 0;
        #1;
        ntot++; if (grant !== 2'd0) $display("FAIL reset_grant: got %0d exp 0", grant); else npass++;
        ntot++;
        if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0)
            $display("FAIL reset_s_valid: got %b exp 00000",
                     {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready});
        else npass++;
        ntot++;
        if ({ifu_arready, lsu_arready, lsu_awready, lsu_wready,
             ifu_rvalid, lsu_rvalid, lsu_bvalid} !== 7'b0)
            $display("FAIL reset_m_outs: got %b exp 0000000",
                     {ifu_arready, lsu_arready, lsu_awready, lsu_wready,
                      ifu_rvalid, lsu_rvalid, lsu_bvalid});
        else npass++;
    endtask

    task automatic test_ifu_only();
        do_reset();
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; s_arready = 1; ifu_rready = 1;
        #1;
        ntot++;
        if (s_arvalid !== 1'b0 || ifu_arready !== 1'b0)
            $display("FAIL ifu_idle_block: got arvalid=%b arready=%b exp 0 0", s_arvalid, ifu_arready);
        else npass++;
        tick();
        ntot++; if (grant !== 2'd1) $display("FAIL ifu_grant: got %0d exp 1", grant); else npass++;
        ntot++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || ifu_arready !== 1'b1)
            $display("FAIL ifu_ar_pass: got v=%b a=%h r=%b exp 1 80000000 1",
                     s_arvalid, s_araddr, ifu_arready);
        else npass++;
        tick();
        ifu_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'd0;
        #1;
        ntot++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || s_rready !== 1'b1)
            $display("FAIL ifu_r_pass: got v=%b d=%h rr=%b exp 1 00000413 1",
                     ifu_rvalid, ifu_rdata, s_rready);
        else npass++;
        ntot++; if (lsu_rvalid !== 1'b0) $display("FAIL ifu_r_leak: got %b exp 0", lsu_rvalid); else npass++;
        tick();
        s_rvalid = 0;
        #1;
        ntot++; if (grant !== 2'd0) $display("FAIL ifu_back_idle: got %0d exp 0", grant); else npass++;
    endtask

    task automatic test_conflict_fixed();
        do_reset();
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1;
        s_arready = 1; ifu_rready = 1; lsu_rready = 1;
        tick();
        ntot++; if (grant !== 2'd2) $display("FAIL conf_grant_lsu: got %0d exp 2", grant); else npass++;
        ntot++;
        if (s_araddr !== 32'h8000_1000 || ifu_arready !== 1'b0 || lsu_arready !== 1'b1)
            $display("FAIL conf_lsu_ar: got a=%h ir=%b lr=%b exp 80001000 0 1",
                     s_araddr, ifu_arready, lsu_arready);
        else npass++;
        tick();
        lsu_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0000_A5A5;
        #1;
        ntot++;
        if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0 || ifu_arready !== 1'b0)
            $display("FAIL conf_lsu_r: got lv=%b iv=%b ir=%b exp 1 0 0",
                     lsu_rvalid, ifu_rvalid, ifu_arready);
        else npass++;
        tick();
        s_rvalid = 0;
        #1;
        ntot++;
        if (grant !== 2'd0 || ifu_arready !== 1'b0)
            $display("FAIL conf_gap: got g=%0d ir=%b exp 0 0", grant, ifu_arready);
        else npass++;
        tick();
        ntot++;
        if (grant !== 2'd1 || s_araddr !== 32'h8000_0004 || ifu_arready !== 1'b1)
            $display("FAIL conf_ifu_ar: got g=%0d a=%h ir=%b exp 1 80000004 1",
                     grant, s_araddr, ifu_arready);
        else npass++;
        tick();
        ifu_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0000_0013;
        #1;
        ntot++;
        if (ifu_rvalid !== 1'b1 || lsu_rvalid !== 1'b0 || ifu_rdata !== 32'h0000_0013)
            $display("FAIL conf_ifu_r: got iv=%b lv=%b d=%h exp 1 0 00000013",
                     ifu_rvalid, lsu_rvalid, ifu_rdata);
        else npass++;
        tick();
        s_rvalid = 0;
        tick();
        ntot++; if (grant !== 2'd0) $display("FAIL conf_end_idle: got %0d exp 0", grant); else npass++;
    endtask

    task automatic test_lsu_write();
        do_reset();
        lsu_awaddr = 32'h8000_2000; lsu_awvalid = 1;
        s_awready = 1; s_wready = 1; lsu_bready = 1;
        tick();
        ntot++; if (grant !== 2'd3) $display("FAIL wr_grant: got %0d exp 3", grant); else npass++;
        ntot++;
        if (s_awvalid !== 1'b1 || s_awaddr !== 32'h8000_2000 || lsu_awready !== 1'b1 || s_wvalid !== 1'b0)
            $display("FAIL wr_aw_pass: got v=%b a=%h r=%b wv=%b exp 1 80002000 1 0",
                     s_awvalid, s_awaddr, lsu_awready, s_wvalid);
        else npass++;
        tick();
        s_bvalid = 1;
        #1;
        ntot++;
        if (s_awvalid !== 1'b0 || lsu_awready !== 1'b0)
            $display("FAIL wr_aw_block: got v=%b r=%b exp 0 0", s_awvalid, lsu_awready);
        else npass++;
        ntot++;
        if (lsu_bvalid !== 1'b0 || s_bready !== 1'b0)
            $display("FAIL wr_b_early: got bv=%b br=%b exp 0 0", lsu_bvalid, s_bready);
        else npass++;
        tick();
        lsu_awvalid = 0; s_bvalid = 0;
        lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
        #1;
        ntot++;
        if (s_wvalid !== 1'b1 || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'b0011 || lsu_wready !== 1'b1)
            $display("FAIL wr_w_pass: got v=%b d=%h s=%b r=%b exp 1 deadbeef 0011 1",
                     s_wvalid, s_wdata, s_wstrb, lsu_wready);
        else npass++;
        tick();
        lsu_wvalid = 0; s_bvalid = 1; s_bresp = 2'd0;
        #1;
        ntot++;
        if (lsu_bvalid !== 1'b1 || lsu_bresp !== 2'd0 || s_bready !== 1'b1 || grant !== 2'd3)
            $display("FAIL wr_b_pass: got bv=%b br=%0d sbr=%b g=%0d exp 1 0 1 3",
                     lsu_bvalid, lsu_bresp, s_bready, grant);
        else npass++;
        tick();
        s_bvalid = 0;
        #1;
        ntot++; if (grant !== 2'd0) $display("FAIL wr_end_idle: got %0d exp 0", grant); else npass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        lsu_araddr = 32'h8000_3000; lsu_arvalid = 1; s_arready = 1;
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1; lsu_rready = 0;
        tick();
        tick();
        lsu_arvalid = 0; s_rvalid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            ntot++;
            if (grant !== 2'd2 || ifu_arready !== 1'b0 || s_arvalid !== 1'b0 || lsu_rvalid !== 1'b1)
                $display("FAIL bp_hold%0d: got g=%0d ir=%b av=%b lv=%b exp 2 0 0 1",
                         i, grant, ifu_arready, s_arvalid, lsu_rvalid);
            else npass++;
            tick();
        end
        lsu_rready = 1;
        tick();
        s_rvalid = 0;
        tick();
        ntot++; if (grant !== 2'd1) $display("FAIL bp_then_ifu: got %0d exp 1", grant); else npass++;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        lsu_awaddr = 32'h8000_4000; lsu_awvalid = 1; s_awready = 1; lsu_bready = 1;
        tick();
        tick();
        lsu_awvalid = 0; rst = 1;
        tick();
        rst = 0;
        #1;
        ntot++;
        if (grant !== 2'd0 || s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || s_bready !== 1'b0)
            $display("FAIL rst_mid_outs: got g=%0d av=%b wv=%b br=%b exp 0 0 0 0",
                     grant, s_awvalid, s_wvalid, s_bready);
        else npass++;
        s_bvalid = 1;
        #1;
        ntot++; if (lsu_bvalid !== 1'b0) $display("FAIL rst_late_b: got %b exp 0", lsu_bvalid); else npass++;
        tick();
        ntot++;
        if (lsu_bvalid !== 1'b0 || grant !== 2'd0)
            $display("FAIL rst_late_b2: got bv=%b g=%0d exp 0 0", lsu_bvalid, grant);
        else npass++;
        s_bvalid = 0; lsu_awvalid = 1;
        tick();
        ntot++;
        if (grant !== 2'd3 || s_awvalid !== 1'b1)
            $display("FAIL rst_flags_clr: got g=%0d av=%b exp 3 1", grant, s_awvalid);
        else npass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] seq_b [4];
        logic [1:0] seq_a [4];
        int nb = 0;
        int na = 0;
        logic [1:0] prev_a = 2'd0;
        logic [1:0] prev_b = 2'd0;
        do_reset();
        ifu_araddr = 32'h8000_0010; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_5000; lsu_arvalid = 1;
        s_arready = 1; s_rvalid = 1; ifu_rready = 1; lsu_rready = 1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (prev_b == 2'd0 && grant_b != 2'd0 && nb < 4) begin
                seq_b[nb] = grant_b;
                nb++;
            end
            if (prev_a == 2'd0 && grant != 2'd0 && na < 4) begin
                seq_a[na] = grant;
                na++;
            end
            prev_b = grant_b;
            prev_a = grant;
        end
        ntot++; if (nb != 4) $display("FAIL rr_count: got %0d exp 4", nb); else npass++;
        ntot++; if (na != 4) $display("FAIL fp_count: got %0d exp 4", na); else npass++;
        for (int k = 0; k < nb; k++) begin
            ntot++;
            if (seq_b[k] !== ((k % 2 == 0) ? 2'd2 : 2'd1))
                $display("FAIL rr_seq%0d: got %0d exp %0d", k, seq_b[k], (k % 2 == 0) ? 2 : 1);
            else npass++;
        end
        for (int k = 0; k < na; k++) begin
            ntot++;
            if (seq_a[k] !== 2'd2)
                $display("FAIL fp_seq%0d: got %0d exp 2", k, seq_a[k]);
            else npass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_ifu_only();
        test_conflict_fixed();
        test_lsu_write();
        test_backpressure();
        test_reset_mid_write();
        test_round_robin();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
